// File: rtl/morse_pkg.sv
// Shared constants for the Morse receive path: letter codes, FSM states, letter table.
package morse_pkg;

  localparam logic [2:0] CODE_S = 3'b000;
  localparam logic [2:0] CODE_T = 3'b001;
  localparam logic [2:0] CODE_U = 3'b010;
  localparam logic [2:0] CODE_V = 3'b011;
  localparam logic [2:0] CODE_W = 3'b100;
  localparam logic [2:0] CODE_X = 3'b101;
  localparam logic [2:0] CODE_Y = 3'b110;
  localparam logic [2:0] CODE_Z = 3'b111;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  localparam int UNITS_DASH       = 3;
  localparam int UNITS_LETTER_GAP = 3;

  localparam int CNT_W = 3;
  localparam int PAT_W = 4;
  localparam int LEN_W = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_MARK   = 3'd1;
  localparam logic [2:0] ST_SPACE  = 3'd2;
  localparam logic [2:0] ST_LOOKUP = 3'd3;
  localparam logic [2:0] ST_FLUSH  = 3'd4;

  // Keys are {count, pattern}; symbols enter the pattern LSB and shift left.
  localparam logic [6:0] KEY_S = 7'b011_0000;
  localparam logic [6:0] KEY_T = 7'b001_0001;
  localparam logic [6:0] KEY_U = 7'b011_0001;
  localparam logic [6:0] KEY_V = 7'b100_0001;
  localparam logic [6:0] KEY_W = 7'b011_0011;
  localparam logic [6:0] KEY_X = 7'b100_1001;
  localparam logic [6:0] KEY_Y = 7'b100_1011;
  localparam logic [6:0] KEY_Z = 7'b100_1100;

  // Returns {hit, code}.
  function automatic logic [3:0] letter_lookup(
    input logic [6:0] key
  );
    logic [3:0] r;
    r = 4'b0000;
    case (key)
      KEY_S:   r = {1'b1, CODE_S};
      KEY_T:   r = {1'b1, CODE_T};
      KEY_U:   r = {1'b1, CODE_U};
      KEY_V:   r = {1'b1, CODE_V};
      KEY_W:   r = {1'b1, CODE_W};
      KEY_X:   r = {1'b1, CODE_X};
      KEY_Y:   r = {1'b1, CODE_Y};
      KEY_Z:   r = {1'b1, CODE_Z};
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Morse unit down-counter: strobes tick once per unit while running.
module morse_unit_timer #(
  parameter int TICKS_PER_UNIT = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic load_half,
  output logic tick
);

  localparam int W = $clog2(TICKS_PER_UNIT + 1);
  localparam logic [W-1:0] TOP  = W'(TICKS_PER_UNIT - 1);
  localparam logic [W-1:0] HALF = W'(TICKS_PER_UNIT / 2);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load_half) begin
      cnt <= HALF;
    end else if (run) begin
      cnt <= (cnt == '0) ? TOP : cnt - 1'b1;
    end
  end

  assign tick = run && (cnt == '0);

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: measures marks/spaces at unit rate and decodes letters S..Z.
// Build option MORSE_DEC_TOLERANT_EN widens the accepted dash length to 2..4 units.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int TICKS_PER_UNIT = 25000000,
  parameter int MAX_SYMBOLS    = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic       din,
  output logic [2:0] code,
  output logic       valid,
  output logic       error,
  output logic       busy
);

  logic [2:0]       state;
  logic [LEN_W-1:0] mark_len;
  logic [LEN_W-1:0] space_len;
  logic [CNT_W-1:0] count;
  logic [PAT_W-1:0] pattern;

  logic tick;
  logic clr;
  logic sym_ok;
  logic sym;
  logic full;
  logic [3:0] hit_code;

  localparam logic [LEN_W-1:0] LEN_DASH = LEN_W'(UNITS_DASH);
  localparam logic [LEN_W-1:0] GAP_LAST = LEN_W'(UNITS_LETTER_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_SYMBOLS);

  assign clr  = reset || !enable;
  assign busy = (state != ST_IDLE);
  assign full = (count == CNT_MAX);

  morse_unit_timer #(
    .TICKS_PER_UNIT(TICKS_PER_UNIT)
  ) u_timer (
    .clk      (CLOCK_50),
    .reset    (clr),
    .run      (state != ST_IDLE),
    .load_half(state == ST_IDLE && din),
    .tick     (tick)
  );

  always_comb begin
    sym_ok = 1'b0;
    sym    = DOT;
`ifdef MORSE_DEC_TOLERANT_EN
    if (mark_len == 3'd1) begin
      sym_ok = 1'b1;
      sym    = DOT;
    end else if (mark_len >= 3'd2 && mark_len <= 3'd4) begin
      sym_ok = 1'b1;
      sym    = DASH;
    end
`else
    if (mark_len == 3'd1) begin
      sym_ok = 1'b1;
      sym    = DOT;
    end else if (mark_len == LEN_DASH) begin
      sym_ok = 1'b1;
      sym    = DASH;
    end
`endif
  end

  assign hit_code = letter_lookup({count, pattern});

  always_ff @(posedge CLOCK_50) begin
    if (clr) begin
      state     <= ST_IDLE;
      mark_len  <= '0;
      space_len <= '0;
      count     <= '0;
      pattern   <= '0;
      code      <= 3'b000;
      valid     <= 1'b0;
      error     <= 1'b0;
    end else begin
      valid <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: begin
          count   <= '0;
          pattern <= '0;
          if (din) begin
            state    <= ST_MARK;
            mark_len <= '0;
          end
        end
        ST_MARK: begin
          if (tick) begin
            if (din) begin
              if (mark_len == 3'd6) begin
                mark_len  <= 3'd7;
                error     <= 1'b1;
                space_len <= '0;
                state     <= ST_FLUSH;
              end else begin
                mark_len <= mark_len + 3'd1;
              end
            end else if (!sym_ok || full) begin
              // The falling sample already counts as the first space unit.
              error     <= 1'b1;
              space_len <= 3'd1;
              state     <= ST_FLUSH;
            end else begin
              pattern   <= {pattern[PAT_W-2:0], sym};
              count     <= count + 3'd1;
              space_len <= 3'd1;
              state     <= ST_SPACE;
            end
          end
        end
        ST_SPACE: begin
          if (tick) begin
            if (din) begin
              mark_len <= 3'd1;
              state    <= ST_MARK;
            end else begin
              space_len <= space_len + 3'd1;
              if (space_len == GAP_LAST) begin
                state <= ST_LOOKUP;
              end
            end
          end
        end
        ST_LOOKUP: begin
          if (hit_code[3]) begin
            code  <= hit_code[2:0];
            valid <= 1'b1;
          end else begin
            error <= 1'b1;
          end
          count   <= '0;
          pattern <= '0;
          state   <= ST_IDLE;
        end
        ST_FLUSH: begin
          if (tick) begin
            if (din) begin
              space_len <= '0;
            end else if (space_len == GAP_LAST) begin
              count   <= '0;
              pattern <= '0;
              state   <= ST_IDLE;
            end else begin
              space_len <= space_len + 3'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder with four clocks per Morse unit.
module tb_morse_decoder;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       din;
  logic [2:0] code;
  logic       valid;
  logic       error;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int n_valid = 0;
  int n_err   = 0;
  int n_both  = 0;
  int v_run   = 0;
  int v_max   = 0;
  int v0;
  int e0;

  morse_decoder #(
    .TICKS_PER_UNIT(4),
    .MAX_SYMBOLS   (4)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .enable  (enable),
    .din     (din),
    .code    (code),
    .valid   (valid),
    .error   (error),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) n_valid++;
    if (error) n_err++;
    if (valid && error) n_both++;
    v_run = valid ? v_run + 1 : 0;
    if (v_run > v_max) v_max = v_run;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      din = (s[i] == "1");
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic mark_start;
    v0 = n_valid;
    e0 = n_err;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    din    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_code", int'(code), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_busy", int'(busy), 0);

    // S
    mark_start();
    send("1");
    chk("s_busy_mid", int'(busy), 1);
    send("0101000");
    send("00");
    chk("s_valid", n_valid - v0, 1);
    chk("s_code", int'(code), 0);
    chk("s_error", n_err - e0, 0);
    chk("s_busy_after", int'(busy), 0);

    // Z, code held at S until the pulse
    mark_start();
    send("1110111");
    chk("z_hold", int'(code), 0);
    chk("z_no_early", n_valid - v0, 0);
    send("0101000");
    send("00");
    chk("z_valid", n_valid - v0, 1);
    chk("z_code", int'(code), 7);
    chk("z_error", n_err - e0, 0);

    // E is not in the table
    mark_start();
    send("1000");
    send("00");
    chk("e_error", n_err - e0, 1);
    chk("e_valid", n_valid - v0, 0);
    chk("e_code", int'(code), 7);

    // five dots overflow, then T
    mark_start();
    send("101010101000");
    send("00");
    chk("ovf_error", n_err - e0, 1);
    chk("ovf_valid", n_valid - v0, 0);
    chk("ovf_busy", int'(busy), 0);
    mark_start();
    send("111000");
    send("00");
    chk("t_valid", n_valid - v0, 1);
    chk("t_code", int'(code), 1);
    chk("t_error", n_err - e0, 0);

    // two-unit mark
    mark_start();
    send("11000");
    send("00");
`ifdef MORSE_DEC_TOLERANT_EN
    chk("len2_valid", n_valid - v0, 1);
    chk("len2_error", n_err - e0, 0);
`else
    chk("len2_valid", n_valid - v0, 0);
    chk("len2_error", n_err - e0, 1);
`endif
    chk("len2_code", int'(code), 1);

    // reset mid-letter
    mark_start();
    send("10111");
    reset = 1'b1;
    din   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_code", int'(code), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_error", int'(error), 0);
    chk("mid_rst_busy", int'(busy), 0);
    send("00");
    chk("mid_rst_pulses", (n_valid - v0) + (n_err - e0), 0);
    mark_start();
    send("10101110000");
    send("00");
    chk("u_valid", n_valid - v0, 1);
    chk("u_code", int'(code), 2);
    chk("u_error", n_err - e0, 0);

    // enable dropped mid-letter
    mark_start();
    send("101");
    enable = 1'b0;
    din    = 1'b0;
    @(negedge clk);
    chk("en_busy", int'(busy), 0);
    chk("en_code", int'(code), 0);
    enable = 1'b1;
    send("0000");
    chk("en_pulses", (n_valid - v0) + (n_err - e0), 0);
    mark_start();
    send("111000");
    send("00");
    chk("en_t_code", int'(code), 1);
    chk("en_t_valid", n_valid - v0, 1);

    chk("pulse_width", v_max, 1);
    chk("never_both", n_both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
